// File: rtl/spi_reg_arbiter_if.sv
// Bus bundle between the SPI front end, the internal loader, the register RAM and the arbiter.
// Latency: none; this is wiring only.
// Backpressure: SPI strobes are fire-and-forget; internal side uses req/ack; RAM side is never stalled.
interface spi_reg_arbiter_if #(
    parameter int ADDR_BITS = 7,
    parameter int DATA_BITS = 16
);
    // SPI host side
    logic                 spi_rd_stb;
    logic                 spi_wr_stb;
    logic [ADDR_BITS-1:0] spi_addr;
    logic [DATA_BITS-1:0] spi_wr_data;
    logic [DATA_BITS-1:0] spi_rd_data;
    logic                 spi_overrun;
    logic                 ovr_clr;
    // Internal requester side
    logic                 int_req;
    logic                 int_we;
    logic [ADDR_BITS-1:0] int_addr;
    logic [DATA_BITS-1:0] int_wdata;
    logic                 int_ack;
    logic [DATA_BITS-1:0] int_rdata;
    // RAM side
    logic                 mem_en;
    logic                 mem_we;
    logic [ADDR_BITS-1:0] mem_addr;
    logic [DATA_BITS-1:0] mem_wdata;
    logic [DATA_BITS-1:0] mem_rdata;

    // Arbiter view
    modport slave (
        input  spi_rd_stb, spi_wr_stb, spi_addr, spi_wr_data, ovr_clr,
        output spi_rd_data, spi_overrun,
        input  int_req, int_we, int_addr, int_wdata,
        output int_ack, int_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    // Environment view: SPI host, internal loader and RAM
    modport master (
        output spi_rd_stb, spi_wr_stb, spi_addr, spi_wr_data, ovr_clr,
        input  spi_rd_data, spi_overrun,
        output int_req, int_we, int_addr, int_wdata,
        input  int_ack, int_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/spi_reg_arbiter.sv
// Time-shares a single-port register RAM between SPI strobes (priority) and one internal req/ack master.
// Latency: idle SPI read strobe sampled at E0 -> mem_en E1 -> spi_rd_data at E3; internal read ack 3 clk after grant.
// Backpressure: none toward SPI (repeat strobe on a busy pend overwrites and sets spi_overrun); internal waits for int_ack.
module spi_reg_arbiter #(
    parameter int ADDR_BITS = 7,
    parameter int DATA_BITS = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    spi_reg_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        GNT_SPI_RD,
        GNT_SPI_WR,
        GNT_INT,
        CAP_SPI,
        CAP_INT
    } state_t;

    state_t               state_q, state_d;

    logic                 rd_pend_q, rd_pend_d;
    logic                 wr_pend_q, wr_pend_d;
    logic [ADDR_BITS-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_BITS-1:0] wr_data_q, wr_data_d;

    logic                 mem_en_q, mem_en_d;
    logic                 mem_we_q, mem_we_d;
    logic [ADDR_BITS-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_BITS-1:0] mem_wdata_q, mem_wdata_d;

    logic [DATA_BITS-1:0] spi_rd_data_q, spi_rd_data_d;
    logic [DATA_BITS-1:0] int_rdata_q, int_rdata_d;
    logic                 int_ack_q, int_ack_d;
    logic                 ovr_q, ovr_d;

    logic                 grant_rd, grant_wr, grant_int;
    logic                 spi_stb_live;

    // A strobe in flight this cycle will become a pend next cycle; holding off the
    // internal grant for it keeps SPI ahead of a request raised in the same clock.
    assign spi_stb_live = bus.spi_rd_stb | bus.spi_wr_stb;

    // Next-state and grant selection: rd_pend > wr_pend > int_req, one RAM cycle per grant.
    always_comb begin
        state_d   = state_q;
        grant_rd  = 1'b0;
        grant_wr  = 1'b0;
        grant_int = 1'b0;
        case (state_q)
            IDLE: begin
                if (rd_pend_q) begin
                    state_d  = GNT_SPI_RD;
                    grant_rd = 1'b1;
                end else if (wr_pend_q) begin
                    state_d  = GNT_SPI_WR;
                    grant_wr = 1'b1;
                end else if (bus.int_req && !int_ack_q && !spi_stb_live) begin
                    state_d   = GNT_INT;
                    grant_int = 1'b1;
                end
            end
            GNT_SPI_RD: state_d = CAP_SPI;
            GNT_SPI_WR: state_d = IDLE;
            GNT_INT:    state_d = mem_we_q ? IDLE : CAP_INT;
            CAP_SPI:    state_d = IDLE;
            CAP_INT:    state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    // Pend capture, overrun detection, RAM command register and read-data capture.
    always_comb begin
        rd_pend_d     = bus.spi_rd_stb | (rd_pend_q & ~grant_rd);
        wr_pend_d     = bus.spi_wr_stb | (wr_pend_q & ~grant_wr);
        rd_addr_d     = bus.spi_rd_stb ? bus.spi_addr : rd_addr_q;
        wr_addr_d     = bus.spi_wr_stb ? bus.spi_addr : wr_addr_q;
        wr_data_d     = bus.spi_wr_stb ? bus.spi_wr_data : wr_data_q;

        // A pend consumed in the same cycle frees its slot, so the new strobe is not lost.
        ovr_d         = (bus.spi_rd_stb & rd_pend_q & ~grant_rd)
                      | (bus.spi_wr_stb & wr_pend_q & ~grant_wr)
                      | (ovr_q & ~bus.ovr_clr);

        mem_en_d      = grant_rd | grant_wr | grant_int;
        mem_we_d      = grant_wr | (grant_int & bus.int_we);
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        if (grant_rd) begin
            mem_addr_d  = rd_addr_q;
        end else if (grant_wr) begin
            mem_addr_d  = wr_addr_q;
            mem_wdata_d = wr_data_q;
        end else if (grant_int) begin
            mem_addr_d  = bus.int_addr;
            mem_wdata_d = bus.int_wdata;
        end

        spi_rd_data_d = (state_q == CAP_SPI) ? bus.mem_rdata : spi_rd_data_q;
        int_rdata_d   = (state_q == CAP_INT) ? bus.mem_rdata : int_rdata_q;
        int_ack_d     = (state_q == CAP_INT) | ((state_q == GNT_INT) & mem_we_q);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers; reset drops any access in progress without acknowledging it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_pend_q     <= 1'b0;
            wr_pend_q     <= 1'b0;
            rd_addr_q     <= '0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            mem_en_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            spi_rd_data_q <= '0;
            int_rdata_q   <= '0;
            int_ack_q     <= 1'b0;
            ovr_q         <= 1'b0;
        end else begin
            rd_pend_q     <= rd_pend_d;
            wr_pend_q     <= wr_pend_d;
            rd_addr_q     <= rd_addr_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            mem_en_q      <= mem_en_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            spi_rd_data_q <= spi_rd_data_d;
            int_rdata_q   <= int_rdata_d;
            int_ack_q     <= int_ack_d;
            ovr_q         <= ovr_d;
        end
    end

    assign bus.mem_en      = mem_en_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.spi_rd_data = spi_rd_data_q;
    assign bus.int_rdata   = int_rdata_q;
    assign bus.int_ack     = int_ack_q;
    assign bus.spi_overrun = ovr_q;

endmodule

// File: tb/tb_spi_reg_arbiter.sv
// Scoreboard bench for spi_reg_arbiter: directed scenarios followed by randomized traffic from both masters.
// Expected RAM accesses, acks and SPI read data are queued at issue time and retired by a negedge monitor.
// A behavioural RAM and a shadow copy of its intended contents supply the expected read data.
module tb_spi_reg_arbiter;
    localparam int AB = 7;
    localparam int DB = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    spi_reg_arbiter_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) bus ();

    spi_reg_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic          we;
        logic [AB-1:0] addr;
        logic [DB-1:0] data;
    } acc_t;
    typedef struct {
        logic          we;
        logic [DB-1:0] data;
    } ack_t;
    typedef struct {
        logic [DB-1:0] data;
        int            at;
    } rd_t;

    acc_t spi_mem_q[$];
    acc_t int_mem_q[$];
    ack_t int_ack_q[$];
    rd_t  spi_rd_q[$];

    logic [DB-1:0] ram    [0:127];
    logic [DB-1:0] shadow [0:127];
    logic [DB-1:0] last_spi_rd = '0;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int spi_acc_cyc = 0;
    int int_acc_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Single-port RAM, one clock read latency
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            bus.mem_rdata <= ram[bus.mem_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit acc_match(input acc_t e, input logic we, input logic [AB-1:0] a, input logic [DB-1:0] d);
        return (e.we === we) && (e.addr === a) && (!we || (e.data === d));
    endfunction

    // Monitor: retires every RAM access, every int_ack and every due SPI read value
    always @(negedge clk) begin
        if (bus.mem_en) begin
            n_checks++;
            if (spi_mem_q.size() > 0 && acc_match(spi_mem_q[0], bus.mem_we, bus.mem_addr, bus.mem_wdata)) begin
                void'(spi_mem_q.pop_front());
                spi_acc_cyc = cyc;
            end else if (int_mem_q.size() > 0 && acc_match(int_mem_q[0], bus.mem_we, bus.mem_addr, bus.mem_wdata)) begin
                void'(int_mem_q.pop_front());
                int_acc_cyc = cyc;
            end else begin
                n_fail++;
                $display("FAIL mem_access: got we=%0d addr=%0h wdata=%0h, required a matching outstanding request (cycle %0d)",
                         bus.mem_we, bus.mem_addr, bus.mem_wdata, cyc);
            end
        end
        if (bus.int_ack) begin
            if (int_ack_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL int_ack: got unexpected pulse, required none (cycle %0d)", cyc);
            end else begin
                ack_t k;
                k = int_ack_q.pop_front();
                if (!k.we) check("int_rdata", {16'h0, bus.int_rdata}, {16'h0, k.data});
                else       check("int_ack_write", {31'h0, bus.int_ack}, 32'h1);
            end
        end
        while (spi_rd_q.size() > 0 && spi_rd_q[0].at <= cyc) begin
            rd_t r;
            r = spi_rd_q.pop_front();
            check("spi_rd_data", {16'h0, bus.spi_rd_data}, {16'h0, r.data});
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic spi_write(input logic [AB-1:0] addr, input logic [DB-1:0] data);
        acc_t a;
        a.we = 1'b1; a.addr = addr; a.data = data;
        spi_mem_q.push_back(a);
        shadow[addr] = data;
        bus.spi_wr_stb = 1'b1; bus.spi_addr = addr; bus.spi_wr_data = data;
        tick(1);
        bus.spi_wr_stb = 1'b0;
    endtask

    // exact: old value still visible 2 clk after the sampling edge, new value at 3 clk
    task automatic spi_read(input logic [AB-1:0] addr, input bit exact);
        acc_t a;
        rd_t  r;
        a.we = 1'b0; a.addr = addr; a.data = '0;
        spi_mem_q.push_back(a);
        if (exact) begin
            r.data = last_spi_rd; r.at = cyc + 3;
            spi_rd_q.push_back(r);
            r.at = cyc + 4;
        end else begin
            r.at = cyc + 7;
        end
        r.data = shadow[addr];
        spi_rd_q.push_back(r);
        last_spi_rd = shadow[addr];
        bus.spi_rd_stb = 1'b1; bus.spi_addr = addr;
        tick(1);
        bus.spi_rd_stb = 1'b0;
    endtask

    // lat: clocks from the edge that first samples int_req to the edge that raises int_ack
    task automatic int_access(input logic we, input logic [AB-1:0] addr, input logic [DB-1:0] wd, output int lat);
        acc_t a;
        ack_t k;
        int   t0;
        a.we = we; a.addr = addr; a.data = wd;
        int_mem_q.push_back(a);
        k.we = we; k.data = we ? '0 : shadow[addr];
        int_ack_q.push_back(k);
        if (we) shadow[addr] = wd;
        bus.int_req = 1'b1; bus.int_we = we; bus.int_addr = addr; bus.int_wdata = wd;
        t0 = cyc;
        for (int i = 0; i < 40 && !bus.int_ack; i++) tick(1);
        lat = cyc - t0 - 1;
        if (!bus.int_ack) begin
            n_checks++;
            n_fail++;
            $display("FAIL int_ack_timeout: got no ack after 40 clk, required an ack (addr %0h)", addr);
        end
        // Request is still high during the ack cycle; it must not be granted again
        tick(1);
        bus.int_req = 1'b0; bus.int_we = 1'b0;
    endtask

    // Internal read holds the RAM while two SPI writes hit the same pend
    task automatic overrun_pair(input logic [AB-1:0] addr, input logic [DB-1:0] d1, input logic [DB-1:0] d2, input bit clr);
        acc_t a;
        ack_t k;
        a.we = 1'b0; a.addr = 7'h60; a.data = '0;
        int_mem_q.push_back(a);
        k.we = 1'b0; k.data = shadow[7'h60];
        int_ack_q.push_back(k);
        a.we = 1'b1; a.addr = addr; a.data = d2;
        spi_mem_q.push_back(a);
        shadow[addr] = d2;
        bus.int_req = 1'b1; bus.int_we = 1'b0; bus.int_addr = 7'h60;
        for (int i = 0; i < 20 && !bus.mem_en; i++) tick(1);
        check("int_grant_seen", {31'h0, bus.mem_en}, 32'h1);
        bus.spi_wr_stb = 1'b1; bus.spi_addr = addr; bus.spi_wr_data = d1;
        tick(1);
        bus.spi_wr_data = d2; bus.ovr_clr = clr;
        tick(1);
        bus.spi_wr_stb = 1'b0; bus.ovr_clr = 1'b0;
        check(clr ? "spi_overrun_set_beats_clr" : "spi_overrun_set", {31'h0, bus.spi_overrun}, 32'h1);
        for (int i = 0; i < 20 && !bus.int_ack; i++) tick(1);
        check("overrun_int_ack", {31'h0, bus.int_ack}, 32'h1);
        tick(1);
        bus.int_req = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_spi_rd_data"}, {16'h0, bus.spi_rd_data}, 32'h0);
        check({tag, "_int_rdata"},   {16'h0, bus.int_rdata},   32'h0);
        check({tag, "_int_ack"},     {31'h0, bus.int_ack},     32'h0);
        check({tag, "_mem_en"},      {31'h0, bus.mem_en},      32'h0);
        check({tag, "_mem_we"},      {31'h0, bus.mem_we},      32'h0);
        check({tag, "_mem_addr"},    {25'h0, bus.mem_addr},    32'h0);
        check({tag, "_mem_wdata"},   {16'h0, bus.mem_wdata},   32'h0);
        check({tag, "_spi_overrun"}, {31'h0, bus.spi_overrun}, 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        for (int i = 0; i < 128; i++) begin
            ram[i] = '0;
            shadow[i] = '0;
        end
        bus.spi_rd_stb = 1'b0; bus.spi_wr_stb = 1'b0; bus.spi_addr = '0; bus.spi_wr_data = '0;
        bus.ovr_clr = 1'b0;
        bus.int_req = 1'b0; bus.int_we = 1'b0; bus.int_addr = '0; bus.int_wdata = '0;
        bus.mem_rdata = '0;

        // Reset and idle
        tick(3);
        check_outputs_zero("reset");
        reset_n = 1'b1;
        tick(10);
        check_outputs_zero("idle");

        // SPI write then read back with exact latency
        spi_write(7'h12, 16'hBEEF);
        tick(10);
        spi_read(7'h12, 1'b1);
        tick(8);

        // Internal write then read; int_rdata holds across a later write
        int_access(1'b1, 7'h05, 16'h1234, lat);
        int_access(1'b0, 7'h05, 16'h0000, lat);
        tick(3);
        check("int_rdata_hold", {16'h0, bus.int_rdata}, 32'h1234);
        int_access(1'b1, 7'h06, 16'h7777, lat);
        tick(2);
        check("int_rdata_hold_after_write", {16'h0, bus.int_rdata}, 32'h1234);

        // Same-clock conflict: SPI read wins, internal follows
        spi_write(7'h21, 16'hA5A5);
        tick(6);
        int_access(1'b1, 7'h20, 16'h5A5A, lat);
        tick(3);
        fork
            spi_read(7'h21, 1'b1);
            int_access(1'b0, 7'h20, 16'h0000, lat);
        join
        check("conflict_spi_first", {31'h0, (spi_acc_cyc < int_acc_cyc)}, 32'h1);
        check("conflict_int_lat_le6", {31'h0, (lat <= 6)}, 32'h1);
        tick(4);

        // Overrun, clear, and set-beats-clear
        check("overrun_initial", {31'h0, bus.spi_overrun}, 32'h0);
        overrun_pair(7'h30, 16'h1111, 16'h2222, 1'b0);
        tick(4);
        spi_read(7'h30, 1'b1);
        tick(6);
        check("overrun_sticky", {31'h0, bus.spi_overrun}, 32'h1);
        bus.ovr_clr = 1'b1;
        tick(1);
        bus.ovr_clr = 1'b0;
        check("overrun_cleared", {31'h0, bus.spi_overrun}, 32'h0);
        tick(3);
        overrun_pair(7'h31, 16'h3333, 16'h4444, 1'b1);
        tick(5);
        bus.ovr_clr = 1'b1;
        tick(1);
        bus.ovr_clr = 1'b0;
        check("overrun_cleared_again", {31'h0, bus.spi_overrun}, 32'h0);
        tick(3);

        // Reset during an internal read grant: no ack, clean restart
        begin
            acc_t a;
            a.we = 1'b0; a.addr = 7'h50; a.data = '0;
            int_mem_q.push_back(a);
            bus.int_req = 1'b1; bus.int_we = 1'b0; bus.int_addr = 7'h50;
            for (int i = 0; i < 20 && !bus.mem_en; i++) tick(1);
            check("reset_test_grant_seen", {31'h0, bus.mem_en}, 32'h1);
            reset_n = 1'b0;
            tick(2);
            bus.int_req = 1'b0;
            reset_n = 1'b1;
            last_spi_rd = '0;
            check_outputs_zero("midreset");
            tick(6);
            spi_read(7'h12, 1'b1);
            tick(8);
        end

        // Randomized traffic: SPI in 0x00-0x3F at realistic spacing, internal in 0x40-0x7F back to back
        fork
            begin
                for (int n = 0; n < 25; n++) begin
                    logic [AB-1:0] sa;
                    tick($urandom_range(12, 20));
                    sa = AB'($urandom_range(0, 63));
                    if ($urandom_range(0, 1) == 1) spi_write(sa, DB'($urandom));
                    else                           spi_read(sa, 1'b0);
                end
            end
            begin
                for (int n = 0; n < 25; n++) begin
                    int rl;
                    tick($urandom_range(0, 3));
                    int_access(1'($urandom_range(0, 1)), AB'($urandom_range(64, 127)), DB'($urandom), rl);
                end
            end
        join

        tick(20);
        check("drain_spi_mem_q",  spi_mem_q.size(), 32'h0);
        check("drain_int_mem_q",  int_mem_q.size(), 32'h0);
        check("drain_int_ack_q",  int_ack_q.size(), 32'h0);
        check("drain_spi_rd_q",   spi_rd_q.size(),  32'h0);
        check("random_no_overrun", {31'h0, bus.spi_overrun}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
